// File: rtl/fetch_pkg.sv
// Shared types and PC alignment helpers for the fetch PC unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        PARK = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam int MAX_XLEN = 64;

    function automatic int align_bits(input int unsigned instr_bytes);
        return $clog2(instr_bytes);
    endfunction

    // Works on the widest supported PC; callers cast to their own XLEN.
    function automatic logic [MAX_XLEN-1:0] align_pc(input logic [MAX_XLEN-1:0] pc,
                                                     input int bits);
        logic [MAX_XLEN-1:0] mask;
        mask = (64'd1 << bits) - 64'd1;
        return pc & ~mask;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-state / next-PC selection for the fetch FSM: redirect > increment > hold.
// Reset is applied by the registers in fetch_pc_unit, ahead of everything here.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int INSTR_BYTES = 4,
    parameter int ALIGN_BITS  = 2
) (
    input  fetch_state_t    state,
    input  logic [XLEN-1:0] pc,
    input  logic            drop,
    input  logic            we,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic            instr_ready,
    output fetch_state_t    state_nxt,
    output logic [XLEN-1:0] pc_nxt,
    output logic            drop_nxt,
    output logic            capture
);

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;
    fetch_state_t    resume;

    assign target = XLEN'(align_pc(64'(redirect_pc), ALIGN_BITS));
    assign pc_inc = pc + XLEN'(INSTR_BYTES);
    assign resume = we ? REQ : PARK;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        capture   = 1'b0;
        if (redirect_valid) begin
            pc_nxt = target;
        end
        case (state)
            PARK: begin
                if (!redirect_valid && we) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Accepted together with a redirect: the response is already stale.
                if (req_ready) begin
                    state_nxt = WAIT;
                    drop_nxt  = redirect_valid;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    if (drop || redirect_valid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = resume;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_nxt = resume;
                end else if (instr_ready) begin
                    pc_nxt    = pc_inc;
                    state_nxt = resume;
                end
            end
            default: state_nxt = PARK;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Architectural fetch PC with a single-outstanding memory request and a
// valid/ready instruction output towards decode.
//
// state | meaning
// PARK  | idle, no request; leaves when fetch is enabled
// REQ   | request to memory presented at pc_out
// WAIT  | request accepted, waiting for the response (may be marked for drop)
// HOLD  | instruction presented to decode
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_out
);

    localparam int ALIGN_BITS = align_bits(INSTR_BYTES);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            drop;
    logic            drop_nxt;
    logic            capture;

    pc_next_sel #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES),
        .ALIGN_BITS  (ALIGN_BITS)
    ) u_pc_next_sel (
        .state          (state),
        .pc             (pc),
        .drop           (drop),
        .we             (we),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .instr_ready    (instr_ready),
        .state_nxt      (state_nxt),
        .pc_nxt         (pc_nxt),
        .drop_nxt       (drop_nxt),
        .capture        (capture)
    );

    // Handshake valids are decoded from the next state so they leave a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PARK;
            pc          <= RESET_VECTOR;
            drop        <= 1'b0;
            req_valid   <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            drop        <= drop_nxt;
            req_valid   <= (state_nxt == REQ);
            instr_valid <= (state_nxt == HOLD);
            if (capture) begin
                instr    <= rsp_instr;
                instr_pc <= pc;
            end
        end
    end

    assign pc_out   = pc;
    assign req_addr = pc;

    a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        rsp_valid |-> (state == WAIT));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic, checked by
// an architectural PC tracker and a memory whose word is a function of address.
module tb_fetch_pc_unit;

    localparam logic [31:0] RV = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_pc = RV;
    int          acc_cnt = 0;
    logic [31:0] acc_addr;
    int          acc_seen = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt = 0;
    int          mem_lat = 0;
    logic [31:0] dlv_pc[$];
    int          dlv_cyc[$];

    fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .INSTR_BYTES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .we             (we),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_instr      (rsp_instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hDEAD_0000 + a;
    endfunction

    // Architectural tracker, sampled mid-cycle when inputs are settled.
    initial begin
        logic        p_iv, p_ir, p_rv, p_rqv, p_rqr;
        logic [31:0] p_instr, p_ipc, p_addr;
        p_iv = 0; p_ir = 0; p_rv = 0; p_rqv = 0; p_rqr = 0;
        p_instr = 0; p_ipc = 0; p_addr = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst === 1'b1) begin
                exp_pc = RV;
                p_iv = 0;
                p_rqv = 0;
            end else begin
                checks++;
                if (pc_out !== exp_pc) begin
                    errors++;
                    $display("FAIL pc_track cycle %0d: pc_out=%h expected=%h", cyc, pc_out, exp_pc);
                end
                checks++;
                if (req_addr !== pc_out) begin
                    errors++;
                    $display("FAIL req_addr_eq_pc cycle %0d: req_addr=%h pc_out=%h", cyc, req_addr, pc_out);
                end
                if (p_iv && !p_ir && !p_rv) begin
                    checks++;
                    if (instr_valid !== 1'b1 || instr !== p_instr || instr_pc !== p_ipc) begin
                        errors++;
                        $display("FAIL hold_stable cycle %0d: valid=%b instr=%h pc=%h expected 1 %h %h",
                                 cyc, instr_valid, instr, instr_pc, p_instr, p_ipc);
                    end
                end
                if (p_rqv && !p_rqr && !p_rv) begin
                    checks++;
                    if (req_valid !== 1'b1 || req_addr !== p_addr) begin
                        errors++;
                        $display("FAIL req_stable cycle %0d: valid=%b addr=%h expected 1 %h",
                                 cyc, req_valid, req_addr, p_addr);
                    end
                end
                if (instr_valid === 1'b1) begin
                    checks++;
                    if (instr !== mem_word(instr_pc)) begin
                        errors++;
                        $display("FAIL instr_data cycle %0d: instr=%h expected=%h", cyc, instr, mem_word(instr_pc));
                    end
                end
                if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                    checks++;
                    if (instr_pc !== exp_pc) begin
                        errors++;
                        $display("FAIL deliver_pc cycle %0d: instr_pc=%h expected=%h", cyc, instr_pc, exp_pc);
                    end
                    dlv_pc.push_back(instr_pc);
                    dlv_cyc.push_back(cyc);
                end
                if (req_valid === 1'b1 && req_ready === 1'b1) begin
                    acc_addr = req_addr;
                    acc_cnt++;
                end
                p_iv = instr_valid; p_ir = instr_ready; p_rv = redirect_valid;
                p_rqv = req_valid; p_rqr = req_ready;
                p_instr = instr; p_ipc = instr_pc; p_addr = req_addr;
                if (redirect_valid === 1'b1)
                    exp_pc = redirect_pc & ~32'd3;
                else if (instr_valid === 1'b1 && instr_ready === 1'b1)
                    exp_pc = exp_pc + 32'd4;
            end
        end
    end

    // One clock; the memory answers each accepted request once after mem_lat cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_instr = $urandom;
        if (acc_cnt != acc_seen) begin
            acc_seen  = acc_cnt;
            pend      = 1'b1;
            pend_addr = acc_addr;
            pend_cnt  = mem_lat;
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_instr = mem_word(pend_addr);
                pend      = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic wait_deliveries(input int base, input int count, input int bound, input string name);
        int n = 0;
        while (dlv_pc.size() < base + count && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (dlv_pc.size() < base + count) begin
            errors++;
            $display("FAIL %s timeout: delivered=%0d required=%0d", name, dlv_pc.size() - base, count);
        end
    endtask

    task automatic wait_req(input int bound, input string name);
        int n = 0;
        while (req_valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (req_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s req_timeout: req_valid=%b required=1", name, req_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_instr = '0; instr_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({req_valid, instr_valid, instr, instr_pc, pc_out, req_addr} !== {1'b0, 1'b0, 32'd0, 32'd0, RV, RV}) begin
            errors++;
            $display("FAIL reset_values: rv=%b iv=%b instr=%h ipc=%h pc=%h addr=%h required 0 0 0 0 %h %h",
                     req_valid, instr_valid, instr, instr_pc, pc_out, req_addr, RV, RV);
        end
    endtask

    task automatic test_sequential();
        int base = dlv_pc.size();
        we = 1'b1; req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 0;
        rst = 1'b0;
        wait_deliveries(base, 3, 40, "sequential");
        for (int i = 0; i < 3 && base + i < dlv_pc.size(); i++) begin
            checks++;
            if (dlv_pc[base+i] !== RV + 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_pc[%0d]: got=%h required=%h", i, dlv_pc[base+i], RV + 32'(4 * i));
            end
            if (i > 0) begin
                checks++;
                if (dlv_cyc[base+i] - dlv_cyc[base+i-1] != 3) begin
                    errors++;
                    $display("FAIL seq_rate[%0d]: spacing=%0d required=3", i, dlv_cyc[base+i] - dlv_cyc[base+i-1]);
                end
            end
        end
    endtask

    task automatic test_redirect_req();
        int base;
        req_ready = 1'b0;
        wait_req(10, "redirect_req");
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (req_addr !== 32'h0000_2000 || req_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_req_addr: addr=%h valid=%b required 00002000 1", req_addr, req_valid);
        end
        base = dlv_pc.size();
        req_ready = 1'b1;
        wait_deliveries(base, 1, 20, "redirect_req");
        checks++;
        if (dlv_pc.size() > base && dlv_pc[base] !== 32'h0000_2000) begin
            errors++;
            $display("FAIL redirect_req_first: got=%h required=00002000", dlv_pc[base]);
        end
    endtask

    task automatic test_redirect_accept();
        int base;
        req_ready = 1'b0;
        wait_req(10, "redirect_accept");
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1004;
        tick();
        req_ready = 1'b1; redirect_pc = 32'h0000_3000; mem_lat = 1;
        tick();
        redirect_valid = 1'b0; req_ready = 1'b0;
        base = dlv_pc.size();
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_wait: req_valid=%b required=0", req_valid);
        end
        wait_req(10, "redirect_accept");
        checks++;
        if (req_addr !== 32'h0000_3000 || dlv_pc.size() != base) begin
            errors++;
            $display("FAIL accept_drop: addr=%h delivered=%0d required 00003000 0", req_addr, dlv_pc.size() - base);
        end
        req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 0;
        wait_deliveries(base, 1, 20, "redirect_accept");
        checks++;
        if (dlv_pc.size() > base && dlv_pc[base] !== 32'h0000_3000) begin
            errors++;
            $display("FAIL accept_next: got=%h required=00003000", dlv_pc[base]);
        end
    endtask

    task automatic test_hold_stall();
        int n = 0;
        logic [31:0] h_instr, h_pc;
        instr_ready = 1'b0; req_ready = 1'b1; mem_lat = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        h_instr = instr; h_pc = instr_pc;
        checks++;
        if (instr_valid !== 1'b1 || h_pc !== exp_pc) begin
            errors++;
            $display("FAIL hold_enter: valid=%b pc=%h required 1 %h", instr_valid, h_pc, exp_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== h_instr || instr_pc !== h_pc || req_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall[%0d]: iv=%b instr=%h pc=%h rv=%b required 1 %h %h 0",
                         i, instr_valid, instr, instr_pc, req_valid, h_instr, h_pc);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || req_addr !== 32'h0000_4000 || req_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_kill: iv=%b addr=%h rv=%b required 0 00004000 1", instr_valid, req_addr, req_valid);
        end
    endtask

    task automatic test_wrap_and_park();
        int base;
        instr_ready = 1'b1; req_ready = 1'b1; mem_lat = 0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        base = dlv_pc.size();
        wait_deliveries(base, 1, 20, "wrap");
        checks++;
        if (dlv_pc.size() > base && (dlv_pc[base] !== 32'hFFFF_FFFC || pc_out !== 32'd0)) begin
            errors++;
            $display("FAIL wrap: delivered=%h pc_out=%h required fffffffc 00000000", dlv_pc[base], pc_out);
        end
        tick();
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL park_accept: req_valid=%b required=0", req_valid);
        end
        we = 1'b0; mem_lat = 2;
        base = dlv_pc.size();
        wait_deliveries(base, 1, 20, "park");
        checks++;
        if (dlv_pc.size() > base && dlv_pc[base] !== 32'd0) begin
            errors++;
            $display("FAIL park_deliver: got=%h required=00000000", dlv_pc[base]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (req_valid !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 32'd4) begin
                errors++;
                $display("FAIL parked[%0d]: rv=%b iv=%b pc=%h required 0 0 00000004", i, req_valid, instr_valid, pc_out);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int base;
        we = 1'b1; req_ready = 1'b1; mem_lat = 3;
        wait_req(10, "reset_mid");
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({req_valid, instr_valid, instr, instr_pc, pc_out, req_addr} !== {1'b0, 1'b0, 32'd0, 32'd0, RV, RV}) begin
            errors++;
            $display("FAIL reset_async: rv=%b iv=%b instr=%h ipc=%h pc=%h addr=%h required 0 0 0 0 %h %h",
                     req_valid, instr_valid, instr, instr_pc, pc_out, req_addr, RV, RV);
        end
        pend = 1'b0;
        rsp_valid = 1'b1; rsp_instr = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_late_rsp: iv=%b instr=%h required 0 00000000", instr_valid, instr);
        end
        acc_seen = acc_cnt;
        mem_lat = 0;
        rst = 1'b0;
        wait_req(10, "reset_mid");
        checks++;
        if (req_addr !== RV) begin
            errors++;
            $display("FAIL reset_first_req: addr=%h required=%h", req_addr, RV);
        end
        base = dlv_pc.size();
        wait_deliveries(base, 1, 20, "reset_mid");
        checks++;
        if (dlv_pc.size() > base && dlv_pc[base] !== RV) begin
            errors++;
            $display("FAIL reset_first_dlv: got=%h required=%h", dlv_pc[base], RV);
        end
    endtask

    task automatic test_random();
        int base = dlv_pc.size();
        for (int i = 0; i < 400; i++) begin
            we             = ($urandom_range(0, 9) != 0);
            req_ready      = 1'($urandom_range(0, 1));
            instr_ready    = 1'($urandom_range(0, 1));
            mem_lat        = $urandom_range(0, 3);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        checks++;
        if (dlv_pc.size() - base < 10) begin
            errors++;
            $display("FAIL random_progress: delivered=%0d required>=10", dlv_pc.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_req();
        test_redirect_accept();
        test_hold_stall();
        test_wrap_and_park();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
